// File: rtl/div_pkg.sv
// Shared definitions for the GF(2)[x] exact-divider stages of the Toom-K
// interpolation chain.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Number of W-coefficient chunks needed to walk an N-coefficient operand.
    function automatic int chunks(input int n, input int w);
        return n / w;
    endfunction

endpackage

// File: rtl/prefix_xor_chunk.sv
// One W-wide slice of the running prefix XOR: r_j = carry_in ^ c_0 ^ ... ^ c_j.
module prefix_xor_chunk #(
    parameter int W = 8
) (
    input  logic         carry_in,
    input  logic [W-1:0] c,
    output logic [W-1:0] r,
    output logic         carry_out
);

    logic w_acc;

    always_comb begin
        r     = '0;
        w_acc = carry_in;
        for (int i = 0; i < W; i++) begin
            w_acc = w_acc ^ c[i];
            r[i]  = w_acc;
        end
    end

    assign carry_out = r[W-1];

endmodule

// File: rtl/div_by_x_plus_1.sv
// Sequential exact divider by (x+1) over GF(2)[x]: q is the prefix XOR of p,
// produced W coefficients per cycle from the LSB up; err flags p(1) != 0.
module div_by_x_plus_1
    import div_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic         err
);

    localparam int CHUNKS = chunks(N, W);
    localparam int CW     = $clog2(CHUNKS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

    generate
        if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
            $fatal(1, "div_by_x_plus_1: N must be a multiple of W and 1 <= W <= N");
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_op;
    logic [N-1:0]  r_q;
    logic          r_err;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  w_r;
    logic          w_carry_out;
    logic [N-1:0]  w_qsh_next;
    logic          w_accept;
    logic          w_run;
    logic          w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_run    = (r_state == RUN);
    assign w_last   = w_run && (r_cnt == LAST_CNT);

    prefix_xor_chunk #(.W(W)) u_chunk (
        .carry_in  (r_carry),
        .c         (r_op[W-1:0]),
        .r         (w_r),
        .carry_out (w_carry_out)
    );

    // Only the upper N-W quotient bits need to persist between RUN cycles;
    // the newest chunk is merged in combinationally on its way to r_q.
    generate
        if (W == N) begin : g_single
            assign w_qsh_next = w_r;
        end else begin : g_multi
            logic [N-W-1:0] r_qsh;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_qsh <= '0;
                end else if (w_run) begin
                    r_qsh <= w_qsh_next[N-1:W];
                end
            end

            assign w_qsh_next = {w_r, r_qsh};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_q     <= '0;
            r_err   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op    <= p;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_op    <= r_op >> W;
            r_carry <= w_carry_out;
            r_cnt   <= r_cnt + 1'b1;
            // Outputs only move once the whole quotient is known.
            if (w_last) begin
                r_q   <= w_qsh_next;
                r_err <= w_qsh_next[N-1];
            end
        end
    end

    assign q   = r_q;
    assign err = r_err;

endmodule

// File: tb/tb_div_by_x_plus_1.sv
// Self-checking bench for div_by_x_plus_1 (N=64, W=8) against a prefix-XOR
// reference model and carry-less products a*(x+1).
module tb_div_by_x_plus_1;

    localparam int N   = 64;
    localparam int W   = 8;
    localparam int LAT = N / W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] p;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_by_x_plus_1 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .err       (err)
    );

    // Reference: q_i = p_0 ^ ... ^ p_i.
    function automatic logic [N-1:0] model_q(input logic [N-1:0] v);
        logic [N-1:0] res;
        logic         acc;
        res = '0;
        acc = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc    = acc ^ v[i];
            res[i] = acc;
        end
        return res;
    endfunction

    function automatic logic [N-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand and wait (bounded) for out_valid; lat = -1 on timeout.
    task automatic run_op(input logic [N-1:0] val, output int lat, output logic q_moved);
        logic [N-1:0] q0;
        q0       = q;
        in_valid = 1'b1;
        p        = val;
        tick();
        in_valid = 1'b0;
        p        = rand_word();
        lat      = 0;
        q_moved  = 1'b0;
        while (!out_valid && lat < 40) begin
            if (q !== q0) q_moved = 1'b1;
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        $display("op p=%h lat=%0d q=%h err=%b", val, lat, q, err);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p         = '0;
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready actual=%b required=1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || q !== '0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs actual out_valid=%b q=%h err=%b required 0/0/0", out_valid, q, err);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release actual in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [N-1:0] vecs  [5] = '{64'h3, 64'h5, 64'hF, 64'h1, 64'h0};
        logic [N-1:0] exps  [5] = '{64'h1, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        logic         errs  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int           lat;
        logic         moved;
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i], lat, moved);
            n_checks++;
            if (lat !== LAT) begin
                n_errors++;
                $display("FAIL vec_latency p=%h actual=%0d required=%0d", vecs[i], lat, LAT);
            end
            n_checks++;
            if (q !== exps[i] || err !== errs[i]) begin
                n_errors++;
                $display("FAIL vec_result p=%h actual q=%h err=%b required q=%h err=%b",
                         vecs[i], q, err, exps[i], errs[i]);
            end
            n_checks++;
            if (moved !== 1'b0) begin
                n_errors++;
                $display("FAIL vec_q_stable_during_run p=%h actual=changed required=stable", vecs[i]);
            end
            handshake();
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL vec_after_handshake actual in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_divisible();
        logic [N-1:0] a;
        logic [N-1:0] pv;
        int           lat;
        logic         moved;
        for (int i = 0; i < 8; i++) begin
            a     = rand_word();
            a[N-1] = 1'b0;
            pv    = a ^ (a << 1);
            run_op(pv, lat, moved);
            n_checks++;
            if (lat !== LAT || q !== a || err !== 1'b0) begin
                n_errors++;
                $display("FAIL divisible p=%h actual lat=%0d q=%h err=%b required lat=%0d q=%h err=0",
                         pv, lat, q, err, LAT, a);
            end
            handshake();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pv;
        logic [N-1:0] e;
        int           lat;
        logic         moved;
        for (int i = 0; i < 8; i++) begin
            pv = rand_word();
            e  = model_q(pv);
            run_op(pv, lat, moved);
            n_checks++;
            if (lat !== LAT || q !== e || err !== e[N-1]) begin
                n_errors++;
                $display("FAIL random p=%h actual lat=%0d q=%h err=%b required lat=%0d q=%h err=%b",
                         pv, lat, q, err, LAT, e, e[N-1]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a;
        int           lat;
        logic         moved;
        a      = rand_word();
        a[N-1] = 1'b0;
        run_op(a ^ (a << 1), lat, moved);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            p        = rand_word();
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== a || err !== 1'b0) begin
                n_errors++;
                $display("FAIL backpressure_hold cycle=%0d actual out_valid=%b in_ready=%b q=%h err=%b required 1/0/%h/0",
                         i, out_valid, in_ready, q, err, a);
            end
        end
        in_valid = 1'b0;
        handshake();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== a) begin
            n_errors++;
            $display("FAIL backpressure_release actual in_ready=%b out_valid=%b q=%h required 1/0/%h",
                     in_ready, out_valid, q, a);
        end
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        logic moved;
        logic saw_valid;
        run_op(64'h1, lat, moved);
        handshake();
        in_valid = 1'b1;
        p        = rand_word();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== '0 || err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_run actual q=%h err=%b out_valid=%b in_ready=%b required 0/0/0/1",
                     q, err, out_valid, in_ready);
        end
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_stale_valid actual=pulse required=none");
        end
        run_op(64'h3, lat, moved);
        n_checks++;
        if (lat !== LAT || q !== 64'h1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_next_op actual lat=%0d q=%h err=%b required lat=%0d q=1 err=0", lat, q, err, LAT);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_q [$];
        logic [N-1:0] e;
        logic         acc;
        logic         hs;
        int           cyc;
        int           last_acc;
        int           n_out;
        cyc       = 0;
        last_acc  = -1;
        n_out     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        p         = rand_word();
        while (n_out < 6 && cyc < 200) begin
            acc = in_ready && in_valid;
            hs  = out_valid && out_ready;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_unexpected_output actual q=%h required no output", q);
                end else begin
                    e = exp_q.pop_front();
                    if (q !== e || err !== e[N-1]) begin
                        n_errors++;
                        $display("FAIL b2b_result idx=%0d actual q=%h err=%b required q=%h err=%b",
                                 n_out, q, err, e, e[N-1]);
                    end
                end
                $display("b2b out idx=%0d cycle=%0d q=%h err=%b", n_out, cyc, q, err);
                n_out++;
            end
            if (acc) begin
                exp_q.push_back(model_q(p));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != LAT + 2) begin
                        n_errors++;
                        $display("FAIL b2b_spacing actual=%0d required=%0d", cyc - last_acc, LAT + 2);
                    end
                end
                last_acc = cyc;
            end
            tick();
            cyc++;
            if (acc) p = rand_word();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_out != 6) begin
            n_errors++;
            $display("FAIL b2b_timeout actual outputs=%0d required=6", n_out);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_divisible();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
